// File: rtl/kmer_buffer_ctrl.sv
// Arbitrates NUM_REQ byte streams into a shared 32-bit packing buffer and
// hands each completed 4-byte k-mer downstream with its source ID.
module kmer_buffer_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 flush,
    output logic [7:0]           buf_data_in,
    output logic                 buf_write_en,
    output logic                 buf_read_en,
    input  logic [31:0]          buf_data_out,
    input  logic                 buf_full,
    input  logic                 buf_empty,
    output logic                 kmer_valid,
    output logic [31:0]          kmer_data,
    output logic [SRC_W-1:0]     kmer_src,
    input  logic                 kmer_ready,
    output logic                 busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam int unsigned NR = NUM_REQ;

    logic [1:0]       state;
    logic [SRC_W-1:0] owner;
    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] next_owner;
    logic [1:0]       byte_cnt;
    logic             fill_ok;
    logic             accept;
    logic             drain_load;
    logic             flush_read;
    logic [7:0]       owner_byte;

    // Round-robin scan starting just after the previous owner.
    always_comb begin
        int unsigned idx;
        logic        found;
        next_owner = '0;
        found      = 1'b0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = (32'(last_grant) + k) % NR;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                next_owner = SRC_W'(idx);
            end
        end
    end

    assign owner_byte = req_data[32'(owner)*8 +: 8];

    // Outputs are gated by rst_n so nothing leaks out while reset is held.
    assign fill_ok      = rst_n && (state == FILL) && !flush && !buf_full;
    assign accept       = fill_ok && req_valid[owner];
    assign drain_load   = rst_n && (state == DRAIN) && !flush && buf_full;
    assign flush_read   = rst_n && flush && (state != OUT) && !buf_empty;

    assign req_ready    = fill_ok ? (NUM_REQ'(1) << owner) : '0;
    assign buf_write_en = accept;
    assign buf_data_in  = accept ? owner_byte : '0;
    assign buf_read_en  = drain_load || flush_read;
    assign kmer_valid   = rst_n && (state == OUT);
    assign busy         = rst_n && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            byte_cnt   <= '0;
            last_grant <= SRC_W'(NUM_REQ - 1);
            kmer_data  <= '0;
            kmer_src   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner <= next_owner;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        byte_cnt   <= '0;
                        last_grant <= owner;
                        state      <= IDLE;
                    end else if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        byte_cnt   <= '0;
                        last_grant <= owner;
                        state      <= IDLE;
                    end else if (buf_full) begin
                        kmer_data <= buf_data_out;
                        kmer_src  <= owner;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (kmer_ready) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kmer_buffer_ctrl.sv
// Self-checking bench for kmer_buffer_ctrl: a queue-based word model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_kmer_buffer_ctrl;

    localparam int N  = 3;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_ready;
    logic             flush = 1'b0;
    logic [7:0]       buf_data_in;
    logic             buf_write_en;
    logic             buf_read_en;
    logic [31:0]      buf_data_out = '0;
    logic             buf_full = 1'b0;
    logic             buf_empty = 1'b1;
    logic             kmer_valid;
    logic [31:0]      kmer_data;
    logic [SW-1:0]    kmer_src;
    logic             kmer_ready = 1'b0;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    kmer_buffer_ctrl #(.NUM_REQ(N), .SRC_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .buf_data_in(buf_data_in),
        .buf_write_en(buf_write_en), .buf_read_en(buf_read_en),
        .buf_data_out(buf_data_out), .buf_full(buf_full), .buf_empty(buf_empty),
        .kmer_valid(kmer_valid), .kmer_data(kmer_data), .kmer_src(kmer_src),
        .kmer_ready(kmer_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Word-level model: who owns the buffer, which bytes it has taken so far,
    // and the last word delivered downstream.
    bit         m_known = 0, m_active = 0, m_drain = 0, m_out = 0;
    int         m_owner = 0, m_last = N - 1, m_ksrc = 0;
    logic [7:0] m_bytes[$];
    logic [31:0] m_kdata = '0;

    // Buffer environment state plus strobes sampled from the DUT.
    int          bcnt = 0;
    logic [31:0] bword = '0;
    logic        w_s = 0, r_s = 0;
    logic [7:0]  d_s = '0;

    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic         e_we, e_re, fill;
        logic [7:0]   e_din;
        fill = m_active && !m_drain && !m_out;
        if (!rst_n) begin
            e_ready = '0; e_we = 0; e_re = 0; e_din = '0;
        end else begin
            e_ready = (fill && !flush && !buf_full) ? (N'(1) << m_owner) : '0;
            e_we    = (e_ready != '0) && req_valid[m_owner];
            e_din   = e_we ? req_data[8*m_owner +: 8] : 8'h00;
            e_re    = (flush && !m_out && !buf_empty) || (m_drain && !flush && buf_full);
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("buf_write_en", 32'(buf_write_en), 32'(e_we));
        chk("buf_data_in", 32'(buf_data_in), 32'(e_din));
        chk("buf_read_en", 32'(buf_read_en), 32'(e_re));
        chk("kmer_valid", 32'(kmer_valid), 32'(rst_n && m_out));
        chk("busy", 32'(busy), 32'(rst_n && m_active));
        if (m_known) begin
            chk("kmer_data", kmer_data, m_kdata);
            chk("kmer_src", 32'(kmer_src), 32'(m_ksrc));
        end
        w_s = buf_write_en; r_s = buf_read_en; d_s = buf_data_in;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known = 1; m_active = 0; m_drain = 0; m_out = 0;
            m_owner = 0; m_last = N - 1; m_kdata = '0; m_ksrc = 0;
            m_bytes.delete();
        end else if (!m_active) begin
            if (|req_valid) begin
                for (int k = 1; k <= N; k++) begin
                    if (req_valid[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        break;
                    end
                end
                m_active = 1;
            end
        end else if (m_out) begin
            if (kmer_ready) begin
                m_last = m_owner; m_out = 0; m_active = 0;
            end
        end else if (flush) begin
            m_last = m_owner; m_active = 0; m_drain = 0;
            m_bytes.delete();
        end else if (m_drain) begin
            if (buf_full) begin
                m_kdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                m_ksrc  = m_owner;
                m_drain = 0; m_out = 1;
                m_bytes.delete();
            end
        end else if (!buf_full && req_valid[m_owner]) begin
            m_bytes.push_back(req_data[8*m_owner +: 8]);
            if (m_bytes.size() == 4) m_drain = 1;
        end

        // Simple 4-byte packing buffer driven by the DUT's strobes.
        if (!rst_n || r_s) begin
            bcnt = 0; bword = '0;
        end else if (w_s && bcnt < 4) begin
            bword[8*bcnt +: 8] = d_s;
            bcnt++;
        end
        buf_full     <= (bcnt == 4);
        buf_empty    <= (bcnt == 0);
        buf_data_out <= bword;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; req_valid = '0; flush = 0;
        step(); step();
        rst_n = 1;
    endtask

    initial begin
        logic [7:0]  tbl[4];
        int          nwe, nre, got;
        int          srcs[$];
        logic [31:0] held;
        tbl = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Single word from requester 0, minimum-latency path.
        do_reset();
        @(negedge clk);
        chk("reset_kmer_data", kmer_data, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        step();
        kmer_ready = 1; req_data = 24'($urandom);
        req_valid = 3'b001; req_data[7:0] = tbl[0];
        nwe = 0; nre = 0;
        step();
        for (int b = 0; b < 4; b++) begin
            req_data[7:0] = tbl[b];
            @(negedge clk);
            nwe += int'(buf_write_en); nre += int'(buf_read_en);
            step();
        end
        req_valid = '0;
        @(negedge clk);
        nwe += int'(buf_write_en); nre += int'(buf_read_en);
        step();
        @(negedge clk);
        chk("w0_valid", 32'(kmer_valid), 32'h1);
        chk("w0_data", kmer_data, 32'h44332211);
        chk("w0_src", 32'(kmer_src), 32'h0);
        chk("w0_writes", 32'(nwe), 32'd4);
        chk("w0_reads", 32'(nre), 32'd1);
        step();
        @(negedge clk);
        chk("w0_one_cycle", 32'(kmer_valid), 32'h0);

        // Two requesters streaming continuously alternate ownership.
        do_reset();
        req_valid = 3'b011; kmer_ready = 1;
        for (int c = 0; c < 100 && srcs.size() < 3; c++) begin
            req_data = 24'($urandom);
            @(negedge clk);
            if (kmer_valid) srcs.push_back(int'(kmer_src));
            step();
        end
        chk("rr_words", 32'(srcs.size()), 32'd3);
        if (srcs.size() == 3) begin
            chk("rr_src0", 32'(srcs[0]), 32'd0);
            chk("rr_src1", 32'(srcs[1]), 32'd1);
            chk("rr_src2", 32'(srcs[2]), 32'd0);
        end

        // Downstream back-pressure holds the word; flush is ignored in OUT.
        do_reset();
        req_valid = 3'b001; kmer_ready = 0; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            req_data = 24'($urandom);
            @(negedge clk);
            got = int'(kmer_valid);
            step();
        end
        chk("bp_reached_out", 32'(got), 32'd1);
        held = kmer_data;
        req_valid = 3'b111;
        for (int c = 0; c < 10; c++) begin
            flush = c[0];
            @(negedge clk);
            chk("bp_valid", 32'(kmer_valid), 32'h1);
            chk("bp_data", kmer_data, held);
            chk("bp_busy", 32'(busy), 32'h1);
            step();
        end
        flush = 0; kmer_ready = 1;
        step();

        // Flush after three bytes; next grant goes to the other requester.
        do_reset();
        req_valid = 3'b001;
        step();
        step(); step(); step();
        flush = 1; req_valid = 3'b011;
        @(negedge clk);
        chk("fl_read", 32'(buf_read_en), 32'h1);
        chk("fl_no_write", 32'(buf_write_en), 32'h0);
        step();
        flush = 0;
        @(negedge clk);
        chk("fl_idle", 32'(busy), 32'h0);
        step();
        @(negedge clk);
        chk("fl_next_grant", 32'(req_ready), 32'(3'b010));
        step();

        // Reset in the middle of a word.
        rst_n = 0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_read", 32'(buf_read_en), 32'h0);
        step();
        rst_n = 1; req_valid = 3'b111;
        step();
        @(negedge clk);
        chk("rst_first_grant", 32'(req_ready), 32'(3'b001));
        step();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom % 250) != 0;
            req_valid  = N'($urandom) | N'($urandom);
            req_data   = 24'($urandom);
            flush      = ($urandom % 40) == 0;
            kmer_ready = ($urandom % 3) != 0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kmer_buffer_ctrl.md
KMER_BUFFER_CTRL -- requirements
Module: kmer_buffer_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of byte-stream requesters sharing one 32-bit k-mer packing buffer (range 2..8).
REQ-002 Parameter SRC_W, default clog2(NUM_REQ), SHALL set the width of the source-ID tag.
REQ-003 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  SHALL indicate that requester i presents a byte.
REQ-006 req_data  input  8*NUM_REQ  SHALL carry requester i's byte in bits [8i+7:8i].
REQ-007 req_ready  output  NUM_REQ  SHALL indicate that the controller accepts requester i's byte this cycle.
REQ-008 flush  input  1  SHALL abort any partially packed word.
REQ-009 buf_data_in  output  8  SHALL carry the byte written to the packing buffer.
REQ-010 buf_write_en  output  1  SHALL be the buffer write strobe.
REQ-011 buf_read_en  output  1  SHALL be the buffer read/clear strobe.
REQ-012 buf_data_out  input  32  SHALL carry the packed buffer word, byte 0 in [7:0].
REQ-013 buf_full, buf_empty  input  1 each  SHALL carry the buffer status flags.
REQ-014 kmer_valid  output  1  SHALL indicate that kmer_data/kmer_src hold a complete word.
REQ-015 kmer_data  output  32  SHALL carry the registered packed k-mer word.
REQ-016 kmer_src  output  SRC_W  SHALL carry the ID of the requester that supplied the word.
REQ-017 kmer_ready  input  1  SHALL indicate that the downstream consumer accepts the word.
REQ-018 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have exactly four states, IDLE, FILL, DRAIN and OUT, plus registers owner (SRC_W bits), byte_cnt (2 bits) and last_grant (SRC_W bits).
REQ-020 IDLE: if any req_valid bit is set, the FSM SHALL select owner round-robin, scanning from (last_grant+1) mod NUM_REQ upward with wrap, and go to FILL next cycle; no byte is accepted in IDLE.
REQ-021 FILL: req_ready[owner] SHALL equal !buf_full, and all other req_ready bits SHALL be 0.
REQ-022 FILL: on req_valid[owner] && req_ready[owner], buf_write_en SHALL be 1 and buf_data_in SHALL be req_data[owner] in the same cycle (combinational pass-through), and byte_cnt SHALL increment.
REQ-023 When the byte with byte_cnt==3 is accepted, byte_cnt SHALL wrap to 0 and the FSM SHALL go to DRAIN.
REQ-024 If the owner deasserts req_valid mid-word, FILL SHALL hold indefinitely with byte_cnt unchanged and SHALL NOT grant any other requester.
REQ-025 DRAIN: in the first cycle with buf_full==1, the controller SHALL load kmer_data<=buf_data_out and kmer_src<=owner, pulse buf_read_en for exactly that cycle, and go to OUT; while buf_full==0 it SHALL wait.
REQ-026 OUT: kmer_valid SHALL be 1, and kmer_data/kmer_src SHALL be stable until kmer_valid && kmer_ready.
REQ-027 On the OUT handshake, the controller SHALL set last_grant<=owner and go to IDLE.
REQ-028 kmer_valid SHALL be 1 only in OUT; buf_write_en SHALL be 1 only in FILL; buf_write_en and buf_read_en SHALL never both be 1 in the same cycle.
REQ-029 flush in FILL or DRAIN SHALL take priority over a same-cycle byte: no byte is accepted; buf_read_en SHALL pulse if buf_empty==0; byte_cnt SHALL clear; the FSM SHALL go to IDLE; last_grant SHALL be set to owner.
REQ-030 flush in OUT SHALL be ignored, so a completed word is never lost; flush in IDLE SHALL pulse buf_read_en if buf_empty==0.
REQ-031 Minimum cost per word SHALL be 7 cycles: 1 IDLE, 4 FILL, 1 DRAIN, 1 OUT.

Reset
REQ-032 While rst_n==0 at a clock edge, state SHALL become IDLE; byte_cnt, owner, kmer_data and kmer_src SHALL become 0; last_grant SHALL become NUM_REQ-1, so requester 0 wins first.
REQ-033 During and after reset, req_ready, buf_write_en, buf_read_en, kmer_valid and busy SHALL be 0 and buf_data_in SHALL be 0; reset mid-word SHALL discard the partial word without a buf_read_en pulse.

Verification
REQ-034 Requester 0 sends bytes 0x11,0x22,0x33,0x44 with kmer_ready=1 -> exactly 4 buf_write_en pulses, one buf_read_en pulse, then kmer_data=0x44332211, kmer_src=0 for one cycle.
REQ-035 Both requesters hold req_valid continuously for 3 words -> kmer_src sequence is 0,1,0, and req_ready is never high for the non-owner.
REQ-036 Owner stalls 5 cycles after byte 2, then resumes -> byte_cnt holds at 2, no other grant occurs, and the final word is correct.
REQ-037 kmer_ready held 0 for 10 cycles in OUT -> kmer_valid, kmer_data and kmer_src are stable, no new grant occurs and busy=1.
REQ-038 flush asserted after 3 bytes, with buf_empty=0 -> one buf_read_en pulse, IDLE on the next cycle, and the next grant goes to the other requester.
REQ-039 rst_n=0 asserted during FILL -> all outputs 0 at the next edge; after release, the first grant goes to requester 0.
